// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception entry sequencer feeding the PC-source selector
//
// Purpose:
//   Detects invalid-opcode / overflow / divide-by-zero and saves the faulting PC
//   (minus 4) into EPC. It then reads the handler address byte from the vector
//   table and presents it zero-extended on o_handler_pc, with a one-cycle o_pc_load.
//   Sequence: IDLE -> READ (MEM_WAIT cycles) -> LOAD -> IDLE.
//
// Optional feature macro: EXC_COUNT_EN (adds saturating o_exc_count[7:0]).
//
// Ports:
//   i_clk          in   1   system clock, rising edge
//   i_reset        in   1   asynchronous active-low reset
//   i_exc_opcode   in   1   invalid opcode flag (level, sampled in IDLE)
//   i_exc_ovf      in   1   ALU overflow flag
//   i_exc_div0     in   1   divide-by-zero flag
//   i_pc_current   in   32  PC of faulting instruction + 4
//   i_mem_byte     in   8   low MDR byte during vector read
//   o_epc          out  32  exception PC register
//   o_mem_addr     out  32  vector byte address to memory
//   o_mem_rd       out  1   memory read request
//   o_handler_pc   out  32  {24'b0, vector byte}
//   o_pc_load      out  1   one-cycle pulse selecting o_handler_pc into PC
//   o_busy         out  1   high whenever not IDLE
//   o_exc_count    out  8   (EXC_COUNT_EN only) saturating exception count
//   o_exc_cause    out  2   00 none, 01 opcode, 10 overflow, 11 div0

module exception_ctrl #(
  parameter int unsigned VEC_OPCODE = 253,
  parameter int unsigned VEC_OVF    = 254,
  parameter int unsigned VEC_DIV0   = 255,
  parameter int unsigned MEM_WAIT   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_exc_opcode,
  input  logic        i_exc_ovf,
  input  logic        i_exc_div0,
  input  logic [31:0] i_pc_current,
  input  logic [7:0]  i_mem_byte,
  output logic [31:0] o_epc,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic [31:0] o_handler_pc,
  output logic        o_pc_load,
  output logic        o_busy,
`ifdef EXC_COUNT_EN
  output logic [7:0]  o_exc_count,
`endif
  output logic [1:0]  o_exc_cause
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // Counter value on the final READ edge (counter starts at 0 on entry).
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t      r_state;
  logic [2:0]  r_wait_cnt;
  logic [31:0] r_epc;
  logic [31:0] r_mem_addr;
  logic        r_mem_rd;
  logic [31:0] r_handler_pc;
  logic        r_pc_load;
  logic        r_busy;
  logic [1:0]  r_exc_cause;

  logic        w_any_exc;
  logic [1:0]  w_cause;
  logic [31:0] w_vec_addr;

  assign w_any_exc = i_exc_opcode | i_exc_ovf | i_exc_div0;

  // Fixed priority: opcode > overflow > div0.
  always_comb begin
    w_cause    = 2'b00;
    w_vec_addr = 32'd0;
    if (i_exc_opcode) begin
      w_cause    = 2'b01;
      w_vec_addr = 32'(VEC_OPCODE);
    end else if (i_exc_ovf) begin
      w_cause    = 2'b10;
      w_vec_addr = 32'(VEC_OVF);
    end else if (i_exc_div0) begin
      w_cause    = 2'b11;
      w_vec_addr = 32'(VEC_DIV0);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 3'd0;
      r_epc        <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_rd     <= 1'b0;
      r_handler_pc <= 32'd0;
      r_pc_load    <= 1'b0;
      r_busy       <= 1'b0;
      r_exc_cause  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_exc) begin
            // Wraps mod 2^32, so PC 0 yields 32'hFFFFFFFC.
            r_epc       <= i_pc_current - 32'd4;
            r_exc_cause <= w_cause;
            r_mem_addr  <= w_vec_addr;
            r_mem_rd    <= 1'b1;
            r_busy      <= 1'b1;
            r_wait_cnt  <= 3'd0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          // Flags raised here are deliberately ignored: no nesting or queueing.
          if (r_wait_cnt == WAIT_LAST) begin
            r_handler_pc <= {24'd0, i_mem_byte};
            r_mem_rd     <= 1'b0;
            r_pc_load    <= 1'b1;
            r_state      <= S_LOAD;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        S_LOAD: begin
          r_pc_load <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_rd  <= 1'b0;
          r_pc_load <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic [7:0] r_exc_count;

  // Counts detection edges only; saturates rather than wrapping.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_exc_count <= 8'd0;
    end else if (r_state == S_IDLE && w_any_exc && r_exc_count != 8'hFF) begin
      r_exc_count <= r_exc_count + 8'd1;
    end
  end

  assign o_exc_count = r_exc_count;
`endif

  assign o_epc        = r_epc;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd     = r_mem_rd;
  assign o_handler_pc = r_handler_pc;
  assign o_pc_load    = r_pc_load;
  assign o_busy       = r_busy;
  assign o_exc_cause  = r_exc_cause;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl

module tb_exception_ctrl;

  localparam int MEM_WAIT = 2;

  logic        clk;
  logic        rst_n;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [31:0] pc_current;
  logic [7:0]  mem_byte;
  logic [31:0] epc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] handler_pc;
  logic        pc_load;
  logic        busy;
  logic [1:0]  exc_cause;
`ifdef EXC_COUNT_EN
  logic [7:0]  exc_count;
`endif

  typedef struct {
    logic [31:0] epc;
    logic [31:0] addr;
    logic [31:0] hpc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_pass;
  int   n_total;

  exception_ctrl #(.MEM_WAIT(MEM_WAIT)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_exc_opcode (exc_opcode),
    .i_exc_ovf    (exc_ovf),
    .i_exc_div0   (exc_div0),
    .i_pc_current (pc_current),
    .i_mem_byte   (mem_byte),
    .o_epc        (epc),
    .o_mem_addr   (mem_addr),
    .o_mem_rd     (mem_rd),
    .o_handler_pc (handler_pc),
    .o_pc_load    (pc_load),
    .o_busy       (busy),
`ifdef EXC_COUNT_EN
    .o_exc_count  (exc_count),
`endif
    .o_exc_cause  (exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    int busy_seen;
    rst_n = 1'b0; exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    pc_current = 32'h0; mem_byte = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (epc !== 0 || mem_addr !== 0 || handler_pc !== 0 || mem_rd !== 0 ||
        pc_load !== 0 || busy !== 0 || exc_cause !== 2'b00)
      $display("FAIL reset_values epc=%h addr=%h hpc=%h rd=%b ld=%b busy=%b cause=%b required all zero",
               epc, mem_addr, handler_pc, mem_rd, pc_load, busy, exc_cause);
    else n_pass++;
`ifdef EXC_COUNT_EN
    n_total++;
    if (exc_count !== 8'h00) $display("FAIL reset_count got=%h required=00", exc_count);
    else n_pass++;
`endif
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy !== 0 || pc_load !== 0 || mem_rd !== 0) busy_seen++;
    end
    n_total++;
    if (busy_seen != 0) $display("FAIL idle_quiet active_cycles=%0d required=0", busy_seen);
    else n_pass++;
  endtask

  // Drives one exception and checks it end to end. If pulse_mid is set, a
  // div0 pulse is injected during READ and must be ignored.
  task automatic do_exception(input logic opc, input logic ovf, input logic dz,
                              input logic [31:0] pc, input logic [7:0] vb,
                              input bit pulse_mid, input string name);
    exp_t e;
    exp_t got_e;
    int   rd_cycles;
    int   busy_cycles;
    int   waited;
    bit   got;
    e.epc = pc - 32'd4;
    e.hpc = {24'd0, vb};
    if (opc)      begin e.addr = 32'd253; e.cause = 2'b01; end
    else if (ovf) begin e.addr = 32'd254; e.cause = 2'b10; end
    else          begin e.addr = 32'd255; e.cause = 2'b11; end
    sb.push_back(e);

    pc_current = pc; mem_byte = ~vb;
    exc_opcode = opc; exc_ovf = ovf; exc_div0 = dz;
    @(posedge clk); #1;
    exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    n_total++;
    if (mem_addr !== e.addr || busy !== 1'b1 || mem_rd !== 1'b1)
      $display("FAIL %s_entry addr=%0d busy=%b rd=%b required addr=%0d busy=1 rd=1",
               name, mem_addr, busy, mem_rd, e.addr);
    else n_pass++;

    rd_cycles = 0; busy_cycles = 0; waited = 0; got = 0;
    while (!got && waited < 20) begin
      if (mem_rd) rd_cycles++;
      if (busy) busy_cycles++;
      // Only the byte presented for the final READ edge is the real vector.
      mem_byte = (waited == MEM_WAIT - 1) ? vb : ~vb;
      exc_div0 = (pulse_mid && waited == 0) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      waited++;
      if (pc_load) got = 1;
    end
    exc_div0 = 0;
    mem_byte = ~vb;
    if (busy) busy_cycles++;

    n_total++;
    if (!got) begin
      $display("FAIL %s_timeout pc_load not seen within %0d cycles", name, waited);
    end else if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard pc_load with empty scoreboard", name);
    end else begin
      got_e = sb.pop_front();
      if (handler_pc !== got_e.hpc || epc !== got_e.epc || exc_cause !== got_e.cause)
        $display("FAIL %s_result hpc=%h epc=%h cause=%b required hpc=%h epc=%h cause=%b",
                 name, handler_pc, epc, exc_cause, got_e.hpc, got_e.epc, got_e.cause);
      else n_pass++;
    end

    n_total++;
    if (waited != MEM_WAIT || rd_cycles != MEM_WAIT || busy_cycles != MEM_WAIT + 1)
      $display("FAIL %s_timing latency=%0d rd=%0d busy=%0d required %0d/%0d/%0d",
               name, waited, rd_cycles, busy_cycles, MEM_WAIT, MEM_WAIT, MEM_WAIT + 1);
    else n_pass++;

    @(posedge clk); #1;
    n_total++;
    if (pc_load !== 0 || busy !== 0 || epc !== e.epc || exc_cause !== e.cause)
      $display("FAIL %s_exit ld=%b busy=%b epc=%h cause=%b required ld=0 busy=0 epc=%h cause=%b",
               name, pc_load, busy, epc, exc_cause, e.epc, e.cause);
    else n_pass++;
  endtask

  task automatic check_quiet(input string name);
    int extra;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (pc_load || busy) extra++;
    end
    n_total++;
    if (extra != 0) $display("FAIL %s_quiet active_cycles=%0d required=0", name, extra);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_exception(0, 1, 0, 32'h0000_0108, 8'h40, 0, "ovf");
    check_quiet("ovf");
  endtask

  task automatic test_priority();
    do_exception(1, 0, 1, 32'h0000_2000, 8'h9C, 0, "op_div0");
    check_quiet("op_div0");
    do_exception(0, 1, 1, 32'h0000_0300, 8'h11, 0, "ovf_div0");
    do_exception(0, 0, 1, 32'h1234_5678, 8'hFF, 0, "div0");
  endtask

  task automatic test_ignore_busy();
    do_exception(0, 0, 1, 32'h0000_0040, 8'h7A, 1, "div0_nest");
    check_quiet("div0_nest");
  endtask

  task automatic test_pc_wrap();
    do_exception(1, 0, 0, 32'h0000_0000, 8'h00, 0, "pc_wrap");
  endtask

  task automatic test_reset_mid();
    int loads;
    pc_current = 32'h0000_0200; exc_ovf = 1;
    @(posedge clk); #1;
    exc_ovf = 0;
    n_total++;
    if (mem_rd !== 1 || busy !== 1)
      $display("FAIL rstmid_entry rd=%b busy=%b required 1/1", mem_rd, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (mem_rd !== 0 || busy !== 0 || epc !== 0 || exc_cause !== 0 || mem_addr !== 0)
      $display("FAIL rstmid_abort rd=%b busy=%b epc=%h cause=%b addr=%h required all zero",
               mem_rd, busy, epc, exc_cause, mem_addr);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    loads = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (pc_load || busy) loads++;
    end
    n_total++;
    if (loads != 0) $display("FAIL rstmid_no_load active_cycles=%0d required=0", loads);
    else n_pass++;
  endtask

  // A level held across the return to IDLE is taken again.
  task automatic test_level_retake();
    int loads;
    pc_current = 32'h0000_0500; mem_byte = 8'h22; exc_ovf = 1;
    loads = 0;
    repeat (2 * (MEM_WAIT + 2)) begin
      @(posedge clk); #1;
      if (pc_load) loads++;
    end
    exc_ovf = 0;
    n_total++;
    if (loads != 2) $display("FAIL retake_loads got=%0d required=2", loads);
    else n_pass++;
    repeat (MEM_WAIT + 3) @(posedge clk);
    #1;
    n_total++;
    if (busy !== 0 || handler_pc !== 32'h22 || exc_cause !== 2'b10)
      $display("FAIL retake_end busy=%b hpc=%h cause=%b required 0/22/10", busy, handler_pc, exc_cause);
    else n_pass++;
  endtask

`ifdef EXC_COUNT_EN
  task automatic test_count_saturate();
    int loads;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pc_current = 32'h0000_0010; mem_byte = 8'h05; exc_div0 = 1;
    loads = 0;
    repeat (300 * (MEM_WAIT + 2)) begin
      @(posedge clk); #1;
      if (pc_load) loads++;
    end
    exc_div0 = 0;
    repeat (MEM_WAIT + 4) @(posedge clk);
    #1;
    n_total++;
    if (loads != 300) $display("FAIL count_loads got=%0d required=300", loads);
    else n_pass++;
    n_total++;
    if (exc_count !== 8'hFF) $display("FAIL count_saturate got=%h required=FF", exc_count);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_overflow();
    test_priority();
    test_ignore_busy();
    test_pc_wrap();
    test_reset_mid();
    test_level_retake();
`ifdef EXC_COUNT_EN
    test_count_saturate();
`endif
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
